// File: rtl/control_unit.sv
// Hardwired Moore control unit: common fetch (T0-T2) then opcode-specific execute (T3-T7).
// Every control strobe is a flop, decoded from the state being entered so it lines up with that state.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic        pco,
    output logic        pci,
    output logic        pc_inc,
    output logic        iri,
    output logic        mari,
    output logic        mdri,
    output logic        mdr_read,
    output logic        mdro,
    output logic        read,
    output logic        write,
    output logic        ryi,
    output logic        rzi,
    output logic        rzo,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        cout,
    output logic        con_in,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [3:0]  o_dbg_state
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic       pco;
        logic       pci;
        logic       pc_inc;
        logic       iri;
        logic       mari;
        logic       mdri;
        logic       mdr_read;
        logic       mdro;
        logic       read;
        logic       write;
        logic       ryi;
        logic       rzi;
        logic       rzo;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic       baout;
        logic       cout;
        logic       con_in;
        logic [4:0] alu_op;
        logic       run;
    } ctl_t;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_ST  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;
    localparam logic [4:0] OP_BR  = 5'b10011;
    localparam logic [4:0] OP_NOP = 5'b11010;

    state_t     r_state;
    state_t     w_next;
    ctl_t       r_ctl;
    ctl_t       w_ctl;
    logic [4:0] w_op;
    logic       w_alu2;
    logic       w_alu1;
    logic       w_ld;
    logic       w_st;
    logic       w_br;
    logic       w_nop;
    logic       w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_unused_ir = ^ir[26:0];
    assign w_alu2      = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_alu1      = (w_op == OP_NEG) || (w_op == OP_NOT);
    assign w_ld        = (w_op == OP_LD);
    assign w_st        = (w_op == OP_ST);
    assign w_br        = (w_op == OP_BR);
    assign w_nop       = (w_op == OP_NOP);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_RST;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= w_ctl;
        end
    end

    // S_RST is the "T0 pending" state held while clear is low.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = mem_ready ? S_T2 : S_T1;
            S_T2:   w_next = S_T3;
            S_T3: begin
                if (w_alu2 || w_alu1 || w_ld || w_st || w_br) w_next = S_T4;
                else if (w_nop)                               w_next = S_T0;
                else                                          w_next = S_HALT;
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = (w_ld || w_st || w_br) ? S_T6 : S_T0;
            S_T6: begin
                if (w_ld && !mem_ready)  w_next = S_T6;
                else if (w_ld || w_st)   w_next = S_T7;
                else                     w_next = S_T0;
            end
            S_T7:   w_next = (w_st && !mem_ready) ? S_T7 : S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    // Decode the state about to be entered; wait states re-decode to the same strobes.
    always_comb begin
        w_ctl     = '0;
        w_ctl.run = (w_next != S_HALT) && (w_next != S_RST);
        case (w_next)
            S_T0: begin
                w_ctl.pco = 1'b1; w_ctl.mari = 1'b1; w_ctl.pc_inc = 1'b1;
            end
            S_T1: begin
                w_ctl.read = 1'b1; w_ctl.mdr_read = 1'b1; w_ctl.mdri = 1'b1;
            end
            S_T2: begin
                w_ctl.mdro = 1'b1; w_ctl.iri = 1'b1;
            end
            S_T3: begin
                if (w_alu2 || w_alu1) begin
                    w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.ryi = 1'b1;
                end else if (w_ld || w_st) begin
                    w_ctl.grb = 1'b1; w_ctl.baout = 1'b1; w_ctl.ryi = 1'b1;
                end else if (w_br) begin
                    w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.con_in = 1'b1;
                end
            end
            S_T4: begin
                if (w_alu2) begin
                    w_ctl.grc = 1'b1; w_ctl.rout = 1'b1; w_ctl.alu_op = w_op; w_ctl.rzi = 1'b1;
                end else if (w_alu1) begin
                    w_ctl.alu_op = w_op; w_ctl.rzi = 1'b1;
                end else if (w_ld || w_st) begin
                    w_ctl.cout = 1'b1; w_ctl.alu_op = OP_ADD; w_ctl.rzi = 1'b1;
                end else if (w_br) begin
                    w_ctl.pco = 1'b1; w_ctl.ryi = 1'b1;
                end
            end
            S_T5: begin
                if (w_alu2 || w_alu1) begin
                    w_ctl.rzo = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                end else if (w_ld || w_st) begin
                    w_ctl.rzo = 1'b1; w_ctl.mari = 1'b1;
                end else if (w_br) begin
                    w_ctl.cout = 1'b1; w_ctl.alu_op = OP_ADD; w_ctl.rzi = 1'b1;
                end
            end
            S_T6: begin
                if (w_ld) begin
                    w_ctl.read = 1'b1; w_ctl.mdr_read = 1'b1; w_ctl.mdri = 1'b1;
                end else if (w_st) begin
                    w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.mdri = 1'b1;
                end else if (w_br && con_ff) begin
                    w_ctl.rzo = 1'b1; w_ctl.pci = 1'b1;
                end
            end
            S_T7: begin
                if (w_ld) begin
                    w_ctl.mdro = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1;
                end else if (w_st) begin
                    w_ctl.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pco         = r_ctl.pco;
    assign pci         = r_ctl.pci;
    assign pc_inc      = r_ctl.pc_inc;
    assign iri         = r_ctl.iri;
    assign mari        = r_ctl.mari;
    assign mdri        = r_ctl.mdri;
    assign mdr_read    = r_ctl.mdr_read;
    assign mdro        = r_ctl.mdro;
    assign read        = r_ctl.read;
    assign write       = r_ctl.write;
    assign ryi         = r_ctl.ryi;
    assign rzi         = r_ctl.rzi;
    assign rzo         = r_ctl.rzo;
    assign gra         = r_ctl.gra;
    assign grb         = r_ctl.grb;
    assign grc         = r_ctl.grc;
    assign rin         = r_ctl.rin;
    assign rout        = r_ctl.rout;
    assign baout       = r_ctl.baout;
    assign cout        = r_ctl.cout;
    assign con_in      = r_ctl.con_in;
    assign alu_op      = r_ctl.alu_op;
    assign run         = r_ctl.run;
    assign o_dbg_state = r_state;

endmodule
